// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: states, opcodes,
// ALU operations and datapath mux selects.
package multicycle_control_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ULA_W    = 3;
    localparam int unsigned SEL_W    = 2;

    // FSM state encodings, also exported on the debug state port
    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
    localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
    localparam logic [STATE_W-1:0] S_BEQ      = 4'd9;
    localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
    localparam logic [STATE_W-1:0] S_ILLEGAL  = 4'd11;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;

    // ALU operation encodings, shared with the ALU
    localparam logic [ULA_W-1:0] ULA_AND = 3'b000;
    localparam logic [ULA_W-1:0] ULA_OR  = 3'b001;
    localparam logic [ULA_W-1:0] ULA_ADD = 3'b010;
    localparam logic [ULA_W-1:0] ULA_SUB = 3'b110;
    localparam logic [ULA_W-1:0] ULA_SLT = 3'b111;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Successor of DECODE for a given opcode/funct3
    function automatic logic [STATE_W-1:0] decode_next(
        input logic [OPCODE_W-1:0] opcode,
        input logic [FUNCT3_W-1:0] funct3
    );
        logic [STATE_W-1:0] nxt;
        case (opcode)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_RTYPE:          nxt = S_EXECUTER;
            OP_ITYPE:          nxt = S_EXECUTEI;
            OP_BRANCH:         nxt = (funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
            OP_JAL:            nxt = S_JAL;
            default:           nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from aluop class and instruction funct fields.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  aluop_t              aluop,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7b5,
    input  logic                op5,
    output logic [ULA_W-1:0]    ula_control,
    output logic                bad_funct
);

    // op5 separates R-type (SUB allowed) from I-type (funct7b5 is immediate data)
    always_comb begin
        ula_control = ULA_ADD;
        bad_funct   = 1'b0;
        case (aluop)
            ALUOP_ADD: ula_control = ULA_ADD;
            ALUOP_SUB: ula_control = ULA_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ula_control = (op5 && funct7b5) ? ULA_SUB : ULA_ADD;
                    3'b010:  ula_control = ULA_SLT;
                    3'b110:  ula_control = ULA_OR;
                    3'b111:  ula_control = ULA_AND;
                    default: bad_funct   = 1'b1;
                endcase
            end
            default: ula_control = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of a multicycle RISC-V core: sequences fetch, decode and
// per-class execute states and drives datapath enables and mux selects.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                zero,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic                reg_write,
    output logic [ULA_W-1:0]    ula_control,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    logic [STATE_W-1:0]  state_q;
    logic [STATE_W-1:0]  state_d;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7b5;
    aluop_t              aluop;
    logic                bad_funct;
    logic                pc_we;
    logic                mem_we;
    logic                ir_we;
    logic                reg_we;
    logic                illegal_st;
    logic                unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7b5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .ula_control (ula_control),
        .bad_funct   (bad_funct)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore decode of datapath controls
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        adr_src    = ADR_PC;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        reg_we     = 1'b0;
        aluop      = ALUOP_ADD;
        illegal_st = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // branch/jump target computed early into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = decode_next(opcode, funct3);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = ADR_ALUOUT;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_we     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = ADR_ALUOUT;
                mem_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_FUNCT;
                state_d   = bad_funct ? S_ILLEGAL : S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
                state_d   = bad_funct ? S_ILLEGAL : S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_we     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                aluop      = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_we      = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // ALU forms the link value OldPC+4 while ALUOut holds the target
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_we      = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_st = 1'b1;
                state_d    = S_ILLEGAL;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every architectural side effect in the cycle it is seen
    assign pc_write  = pc_we      & ~reset;
    assign mem_write = mem_we     & ~reset;
    assign ir_write  = ir_we      & ~reset;
    assign reg_write = reg_we     & ~reset;
    assign illegal   = illegal_st & ~reset;
    assign state     = state_q;

endmodule
